// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I execute/memory slice: widths, opcodes, func3,
// ALU control, immediate-format and write-back source codes, decoded control bundle.
package rv32i_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } func3_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_func3_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  // br_inv flips the zero flag: taken on !zero instead of zero.
  typedef struct packed {
    logic      is_branch;
    logic      is_jal;
    logic      br_inv;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      alu_src;
    imm_src_e  imm_src;
    wb_src_e   wb_src;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  // alt is func7[5], already qualified by the caller (I-type only honours it for shifts).
  function automatic alu_ctrl_e alu_op_decode(input logic [2:0] func3, input logic alt);
    alu_ctrl_e op;
    case (func3_e'(func3))
      F3_ADD_SUB: if (alt) op = ALU_SUB; else op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: if (alt) op = ALU_SRA; else op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_exec_mem_data_ram.sv
// data_ram: word-addressed data memory, synchronous write, combinational read.
// Optional debug read port enabled by defining DEBUG_PORT_EN.
module data_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_WIDTH-1:0]  w_idx_i,
  input  logic [DATA_WIDTH-1:0] w_dat_i,
  input  logic                  re_i,
  input  logic [IDX_WIDTH-1:0]  r_idx_i,
  output logic [DATA_WIDTH-1:0] r_dat_o
`ifdef DEBUG_PORT_EN
  ,
  input  logic [IDX_WIDTH-1:0]  dbg_idx_i,
  output logic [DATA_WIDTH-1:0] dbg_dat_o
`endif
);

  // NOTE: the array has no reset: its contents must survive rst, and a
  // resettable array would not map onto a RAM macro.
  logic [DATA_WIDTH-1:0] mem_q [2**IDX_WIDTH];

  // NOTE: non-blocking write so a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[w_idx_i] <= w_dat_i;
  end

  assign r_dat_o = re_i ? mem_q[r_idx_i] : '0;

`ifdef DEBUG_PORT_EN
  assign dbg_dat_o = mem_q[dbg_idx_i];
`endif

endmodule

// File: rtl/rv32i_exec_mem.sv
// rv32i_exec_mem: control decoder, ALU, data RAM and write-back mux of a single-cycle RV32I core.
// Defining DEBUG_PORT_EN adds debug_addr/debug_data for direct RAM inspection.
module rv32i_exec_mem #(
  parameter int DATA_WIDTH = rv32i_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rv32i_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] rs1_dat,
  input  logic [DATA_WIDTH-1:0] rs2_dat,
  input  logic [DATA_WIDTH-1:0] immediate,
  input  logic [DATA_WIDTH-1:0] pc_plus_4,
  input  logic                  init_done,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_dat,
  input  logic                  init_we,
  output logic                  branch,
  output logic [2:0]            imm_src,
  output logic                  reg_write,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_zero,
  output logic [DATA_WIDTH-1:0] wb_data
`ifdef DEBUG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
`endif
);

  import rv32i_pkg::*;

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;

  ctrl_t                 ctrl;
  logic [2:0]            func3;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] ram_r_dat;
  logic                  ram_we;
  logic [IDX_WIDTH-1:0]  ram_w_idx;
  logic [DATA_WIDTH-1:0] ram_w_dat;

  assign func3 = instruction[14:12];

  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    ctrl = '0;
    if (!rst) begin
      case (opcode_e'(instruction[6:0]))
        OP_R: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_ctrl  = alu_op_decode(func3, instruction[30]);
        end
        OP_I_ALU: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_ctrl  = alu_op_decode(func3, (func3 == F3_SRL_SRA) && instruction[30]);
        end
        OP_LOAD: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.wb_src    = WB_MEM;
        end
        OP_STORE: begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.imm_src   = IMM_S;
        end
        OP_BRANCH: begin
          ctrl.imm_src = IMM_B;
          ctrl.br_inv  = func3[0] ^ func3[2];
          case (br_func3_e'(func3))
            F3_BEQ, F3_BNE: begin
              ctrl.is_branch = 1'b1;
              ctrl.alu_ctrl  = ALU_SUB;
            end
            F3_BLT, F3_BGE: begin
              ctrl.is_branch = 1'b1;
              ctrl.alu_ctrl  = ALU_SLT;
            end
            F3_BLTU, F3_BGEU: begin
              ctrl.is_branch = 1'b1;
              ctrl.alu_ctrl  = ALU_SLTU;
            end
            default: ctrl.is_branch = 1'b0;
          endcase
        end
        OP_JAL: begin
          ctrl.is_jal    = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.imm_src   = IMM_J;
          ctrl.wb_src    = WB_PC4;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign alu_b = ctrl.alu_src ? immediate : rs2_dat;

  always_comb begin
    alu_result = '0;
    case (ctrl.alu_ctrl)
      ALU_ADD:  alu_result = rs1_dat + alu_b;
      ALU_SUB:  alu_result = rs1_dat - alu_b;
      ALU_AND:  alu_result = rs1_dat & alu_b;
      ALU_OR:   alu_result = rs1_dat | alu_b;
      ALU_XOR:  alu_result = rs1_dat ^ alu_b;
      ALU_SLL:  alu_result = rs1_dat << alu_b[4:0];
      ALU_SRL:  alu_result = rs1_dat >> alu_b[4:0];
      ALU_SRA:  alu_result = $signed(rs1_dat) >>> alu_b[4:0];
      ALU_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1_dat) < $signed(alu_b)};
      ALU_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, rs1_dat < alu_b};
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero  = (alu_result == '0);
  assign branch    = ctrl.is_jal | (ctrl.is_branch & (alu_zero ^ ctrl.br_inv));
  assign imm_src   = ctrl.imm_src;
  assign reg_write = ctrl.reg_write;

  // Until init_done the init port owns the write side; rst blocks writes from both.
  assign ram_we    = ~rst & (init_done ? ctrl.mem_write : init_we);
  assign ram_w_idx = init_done ? alu_result[ADDR_WIDTH-1:2] : init_addr[ADDR_WIDTH-1:2];
  assign ram_w_dat = init_done ? rs2_dat : init_dat;

  data_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_data_ram (
    .clk      (clk),
    .we_i     (ram_we),
    .w_idx_i  (ram_w_idx),
    .w_dat_i  (ram_w_dat),
    .re_i     (ctrl.mem_read),
    .r_idx_i  (alu_result[ADDR_WIDTH-1:2]),
    .r_dat_o  (ram_r_dat)
`ifdef DEBUG_PORT_EN
    ,
    .dbg_idx_i(debug_addr[ADDR_WIDTH-1:2]),
    .dbg_dat_o(debug_data)
`endif
  );

  always_comb begin
    wb_data = '0;
    case (ctrl.wb_src)
      WB_ALU:  wb_data = alu_result;
      WB_MEM:  wb_data = ram_r_dat;
      WB_PC4:  wb_data = pc_plus_4;
      default: wb_data = '0;
    endcase
  end

  logic unused_bits;
`ifdef DEBUG_PORT_EN
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7],
                         init_addr[1:0], debug_addr[1:0]};
`else
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7],
                         init_addr[1:0]};
`endif

endmodule

// File: tb/tb_rv32i_exec_mem.sv
// Self-checking bench for rv32i_exec_mem: ISA-level reference model compared every
// cycle, plus literal directed expectations. Honours DEBUG_PORT_EN when defined.
module tb_rv32i_exec_mem;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic        clk;
  logic        rst;
  logic [31:0] instruction, rs1_dat, rs2_dat, immediate, pc_plus_4;
  logic        init_done;
  logic [9:0]  init_addr;
  logic [31:0] init_dat;
  logic        init_we;
  logic        branch;
  logic [2:0]  imm_src;
  logic        reg_write;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] wb_data;
`ifdef DEBUG_PORT_EN
  logic [9:0]  debug_addr;
  logic [31:0] debug_data;
`endif

  rv32i_exec_mem dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .rs1_dat    (rs1_dat),
    .rs2_dat    (rs2_dat),
    .immediate  (immediate),
    .pc_plus_4  (pc_plus_4),
    .init_done  (init_done),
    .init_addr  (init_addr),
    .init_dat   (init_dat),
    .init_we    (init_we),
    .branch     (branch),
    .imm_src    (imm_src),
    .reg_write  (reg_write),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .wb_data    (wb_data)
`ifdef DEBUG_PORT_EN
    ,
    .debug_addr (debug_addr),
    .debug_data (debug_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        br;
    logic [2:0]  imm;
    logic        rw;
    logic        res_v;
    logic [31:0] res;
    logic        wb_v;
    logic [31:0] wb;
    logic        we;
    logic [7:0]  widx;
    logic [31:0] wdat;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  logic [31:0] mem_model [256];
  logic        pend_we = 1'b0;
  logic [7:0]  pend_idx = '0;
  logic [31:0] pend_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32I semantics of the integer ops; alt is the effective SUB/SRA selector.
  function automatic logic [31:0] isa_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (f3)
      3'd0:    if (alt) r = x - y; else r = x + y;
      3'd1:    r = x << y[4:0];
      3'd2:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    r = (x < y) ? 32'd1 : 32'd0;
      3'd4:    r = x ^ y;
      3'd5:    if (alt) r = $signed(x) >>> y[4:0]; else r = x >> y[4:0];
      3'd6:    r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic exp_t model(input logic r, input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm,
                                 input logic [31:0] pc4, input logic idone,
                                 input logic [9:0] iaddr, input logic [31:0] idat,
                                 input logic iwe);
    exp_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        lt_s, lt_u;
    e    = '0;
    op   = ins[6:0];
    f3   = ins[14:12];
    addr = a + imm;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    if (r) return e;
    case (op)
      OP_R, OP_I: begin
        e.rw    = 1'b1;
        e.res_v = 1'b1;
        e.wb_v  = 1'b1;
        e.res   = isa_op(f3, ins[30] && (op == OP_R || f3 == 3'd5), a, (op == OP_R) ? b : imm);
        e.wb    = e.res;
      end
      OP_L: begin
        e.rw    = 1'b1;
        e.res_v = 1'b1;
        e.res   = addr;
        e.wb_v  = 1'b1;
        e.wb    = mem_model[addr[9:2]];
      end
      OP_S: begin
        e.imm   = 3'b001;
        e.res_v = 1'b1;
        e.res   = addr;
      end
      OP_B: begin
        e.imm   = 3'b010;
        e.res_v = 1'b1;
        case (f3)
          3'd0:    begin e.res = a - b; e.br = (a == b); end
          3'd1:    begin e.res = a - b; e.br = (a != b); end
          3'd4:    begin e.res = {31'd0, lt_s}; e.br = lt_s;  end
          3'd5:    begin e.res = {31'd0, lt_s}; e.br = !lt_s; end
          3'd6:    begin e.res = {31'd0, lt_u}; e.br = lt_u;  end
          default: begin e.res = {31'd0, lt_u}; e.br = !lt_u; end
        endcase
      end
      OP_J: begin
        e.br   = 1'b1;
        e.imm  = 3'b100;
        e.rw   = 1'b1;
        e.wb_v = 1'b1;
        e.wb   = pc4;
      end
      default: e.br = 1'b0;
    endcase
    if (idone) begin
      if (op == OP_S) begin
        e.we   = 1'b1;
        e.widx = addr[9:2];
        e.wdat = b;
      end
    end else if (iwe) begin
      e.we   = 1'b1;
      e.widx = iaddr[9:2];
      e.wdat = idat;
    end
    return e;
  endfunction

  // Compare process: inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk) begin
    automatic exp_t e = model(rst, instruction, rs1_dat, rs2_dat, immediate, pc_plus_4,
                              init_done, init_addr, init_dat, init_we);
    pend_we  <= e.we;
    pend_idx <= e.widx;
    pend_dat <= e.wdat;
    if (chk_en) begin
      check("branch", {31'd0, branch}, {31'd0, e.br});
      check("imm_src", {29'd0, imm_src}, {29'd0, e.imm});
      check("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
      if (e.res_v) begin
        check("alu_result", alu_result, e.res);
        check("alu_zero", {31'd0, alu_zero}, {31'd0, (e.res == 32'd0)});
      end
      if (e.wb_v) check("wb_data", wb_data, e.wb);
`ifdef DEBUG_PORT_EN
      check("debug_data", debug_data, mem_model[debug_addr[9:2]]);
`endif
    end
  end

  always @(posedge clk) begin
    if (pend_we) mem_model[pend_idx] <= pend_dat;
  end

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 10'd0, f3, 5'd0, op};
  endfunction

  task automatic go(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] imm);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    init_done   = 1'b1;
    init_we     = 1'b0;
    init_addr   = 10'($urandom);
    init_dat    = $urandom;
    pc_plus_4   = $urandom;
    instruction = ins;
    rs1_dat     = a;
    rs2_dat     = b;
    immediate   = imm;
`ifdef DEBUG_PORT_EN
    debug_addr  = 10'($urandom);
`endif
  endtask

  task automatic rand_cycle();
    logic [31:0] ins, a, b, imm;
    ins = $urandom;
    a   = $urandom;
    b   = $urandom;
    imm = $urandom;
    if ($urandom_range(0, 3) == 0) b = a;
    case ($urandom_range(0, 7))
      0, 1: ins[6:0] = OP_R;
      2:    ins[6:0] = OP_I;
      3:    ins[6:0] = OP_L;
      4:    ins[6:0] = OP_S;
      5: begin
        ins[6:0] = OP_B;
        case ($urandom_range(0, 5))
          0:       ins[14:12] = 3'd0;
          1:       ins[14:12] = 3'd1;
          2:       ins[14:12] = 3'd4;
          3:       ins[14:12] = 3'd5;
          4:       ins[14:12] = 3'd6;
          default: ins[14:12] = 3'd7;
        endcase
      end
      6: ins[6:0] = OP_J;
      default: begin
        case ($urandom_range(0, 3))
          0:       ins[6:0] = OP_LUI;
          1:       ins[6:0] = 7'b0010111;
          2:       ins[6:0] = 7'b1100111;
          default: ins[6:0] = 7'b0001111;
        endcase
      end
    endcase
    go(ins, a, b, imm);
    if ($urandom_range(0, 15) == 0) begin
      init_done = 1'b0;
      init_we   = 1'($urandom);
    end
    if ($urandom_range(0, 39) == 0) rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d n_err %0d", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    instruction = enc(7'h00, 3'd0, OP_J);
    rs1_dat     = 32'd5;
    rs2_dat     = 32'd5;
    immediate   = 32'd0;
    pc_plus_4   = 32'd4;
    init_done   = 1'b1;
    init_addr   = '0;
    init_dat    = '0;
    init_we     = 1'b0;
`ifdef DEBUG_PORT_EN
    debug_addr  = '0;
`endif
    #3;
    check("rst_branch", {31'd0, branch}, 32'd0);
    check("rst_imm_src", {29'd0, imm_src}, 32'd0);
    check("rst_reg_write", {31'd0, reg_write}, 32'd0);

    // Preload every word so all later loads have a known value.
    for (int i = 0; i < 256; i++) begin
      go(32'h0, $urandom, $urandom, $urandom);
      init_done = 1'b0;
      init_we   = 1'b1;
      init_addr = {i[7:0], 2'($urandom)};
      init_dat  = (i == 0) ? 32'd3 : (i == 1) ? 32'd1 : $urandom;
      if (i == 0) chk_en = 1'b1;
    end

    go(enc(7'h00, 3'd2, OP_L), 32'd0, 32'd0, 32'd0); #3;
    check("lw0", wb_data, 32'd3);
    check("lw0_rw", {31'd0, reg_write}, 32'd1);
    go(enc(7'h00, 3'd2, OP_L), 32'd0, 32'd0, 32'd4); #3;
    check("lw4", wb_data, 32'd1);
    for (int k = 0; k < 2; k++) begin
      go(enc(7'h00, 3'd6, OP_R), 32'd3, 32'd1, 32'd0); #3;
      check("or", wb_data, 32'd3);
      check("or_rw", {31'd0, reg_write}, 32'd1);
      go(enc(7'h00, 3'd7, OP_R), 32'd3, 32'd1, 32'd0); #3;
      check("and", wb_data, 32'd1);
    end

    go(enc(7'h00, 3'd0, OP_R), 32'h7fffffff, 32'd1, 32'd0); #3;
    check("add_wrap", alu_result, 32'h80000000);
    go(enc(7'h20, 3'd0, OP_R), 32'd5, 32'd5, 32'd0); #3;
    check("sub", alu_result, 32'd0);
    check("sub_zero", {31'd0, alu_zero}, 32'd1);
    go(enc(7'h00, 3'd2, OP_R), 32'hffffffff, 32'd1, 32'd0); #3;
    check("slt", alu_result, 32'd1);
    go(enc(7'h00, 3'd3, OP_R), 32'hffffffff, 32'd1, 32'd0); #3;
    check("sltu", alu_result, 32'd0);
    go(enc(7'h20, 3'd5, OP_R), 32'hff000000, 32'd4, 32'd0); #3;
    check("sra", alu_result, 32'hfff00000);
    go(enc(7'h00, 3'd5, OP_R), 32'hff000000, 32'd4, 32'd0); #3;
    check("srl", alu_result, 32'h0ff00000);
    go(enc(7'h20, 3'd5, OP_I), 32'hff000000, 32'd0, 32'h00000404); #3;
    check("srai", alu_result, 32'hfff00000);
    go(enc(7'h20, 3'd0, OP_I), 32'd10, 32'd0, 32'd3); #3;
    check("addi_no_sub", alu_result, 32'd13);

    go(enc(7'h00, 3'd2, OP_S), 32'd8, 32'hdeadbeef, 32'd0); #3;
    check("sw_rw", {31'd0, reg_write}, 32'd0);
    check("sw_imm_src", {29'd0, imm_src}, 32'd1);
    go(enc(7'h00, 3'd2, OP_L), 32'd8, 32'd0, 32'd0); #3;
    check("lw8", wb_data, 32'hdeadbeef);
    go(enc(7'h00, 3'd2, OP_L), 32'd0, 32'd0, 32'h0a); #3;
    check("lw0a", wb_data, 32'hdeadbeef);
    go(enc(7'h00, 3'd2, OP_L), 32'd8, 32'd0, 32'd0);
    init_done = 1'b0;
    init_we   = 1'b1;
    init_addr = 10'h008;
    init_dat  = 32'hcafef00d;
    #3;
    check("rw_same_old", wb_data, 32'hdeadbeef);
    go(enc(7'h00, 3'd2, OP_L), 32'd8, 32'd0, 32'd0); #3;
    check("rw_next_new", wb_data, 32'hcafef00d);

    go(enc(7'h00, 3'd0, OP_B), 32'd5, 32'd5, 32'd0); #3;
    check("beq_eq", {31'd0, branch}, 32'd1);
    check("beq_imm_src", {29'd0, imm_src}, 32'd2);
    go(enc(7'h00, 3'd1, OP_B), 32'd5, 32'd5, 32'd0); #3;
    check("bne_eq", {31'd0, branch}, 32'd0);
    go(enc(7'h00, 3'd0, OP_J), 32'd1, 32'd2, 32'd0);
    pc_plus_4 = 32'h00001234;
    #3;
    check("jal_branch", {31'd0, branch}, 32'd1);
    check("jal_wb", wb_data, 32'h00001234);
    check("jal_imm_src", {29'd0, imm_src}, 32'd4);
    go(enc(7'h7f, 3'd7, OP_LUI), 32'd1, 32'd1, 32'd0); #3;
    check("lui_branch", {31'd0, branch}, 32'd0);
    check("lui_rw", {31'd0, reg_write}, 32'd0);
    check("lui_imm_src", {29'd0, imm_src}, 32'd0);

    go(enc(7'h00, 3'd2, OP_S), 32'd0, 32'h00000055, 32'd0);
    rst = 1'b1;
    #3;
    check("midrst_rw", {31'd0, reg_write}, 32'd0);
    check("midrst_imm_src", {29'd0, imm_src}, 32'd0);
    go(enc(7'h00, 3'd0, OP_J), 32'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #3;
    check("midrst_jal_branch", {31'd0, branch}, 32'd0);
    go(enc(7'h00, 3'd2, OP_L), 32'd0, 32'd0, 32'd0); #3;
    check("ram_kept_after_rst", wb_data, 32'd3);

    for (int n = 0; n < 1500; n++) rand_cycle();

    go(32'h0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
